// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared sequencer state encoding and reset PC default
package cpu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_COMMIT = 3'd3;
  localparam state_t ST_HALT   = 3'd4;

  // Word address of byte 0x3000.
  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0C00;

endpackage

// File: rtl/ret_counter.sv
// rtl/ret_counter.sv - 32-bit retired-instruction counter with clear and enable
module ret_counter (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  // Natural modulo-2^32 wrap; no carry or overflow flag.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - fetch/execute/commit sequencer owning PC, IR and retire count
module pc_seq
  import cpu_pkg::*;
#(
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] NPC,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        exec_done,
  input  logic        stall,
  input  logic        halt_req,
  output logic [29:0] PC,
  output logic        imem_req,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        pc_we,
  output logic [31:0] instr_cnt,
  output logic        halted
);

  state_t      state_q, state_d;
  logic [29:0] pc_q;
  logic [31:0] ir_q;
  logic        ir_valid_q;
  logic        fetch_fire;
  logic        commit_fire;

  assign fetch_fire  = (state_q == ST_FETCH) && imem_ack;
  assign commit_fire = (state_q == ST_COMMIT) && !stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (imem_ack) state_d = ST_EXEC;
      ST_EXEC:   if (exec_done) state_d = ST_COMMIT;
      ST_COMMIT: if (!stall) state_d = halt_req ? ST_HALT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // IR only loads on a FETCH ack, so it stays stable through EXEC and COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_fire) begin
        ir_q       <= imem_rdata;
        ir_valid_q <= 1'b1;
      end
      if (commit_fire) begin
        pc_q       <= NPC;
        ir_valid_q <= 1'b0;
      end
    end
  end

  ret_counter u_ret_counter (
    .clk_i   (clk),
    .clr_i   (rst),
    .en_i    (commit_fire),
    .count_o (instr_cnt)
  );

  assign PC       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign imem_req = (state_q == ST_FETCH);
  assign pc_we    = commit_fire;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - table-driven scoreboard bench for pc_seq
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] NPC;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        exec_done;
  logic        stall;
  logic        halt_req;
  logic [29:0] PC;
  logic        imem_req;
  logic [31:0] ir;
  logic        ir_valid;
  logic        pc_we;
  logic [31:0] instr_cnt;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .NPC        (NPC),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .exec_done  (exec_done),
    .stall      (stall),
    .halt_req   (halt_req),
    .PC         (PC),
    .imem_req   (imem_req),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc_we      (pc_we),
    .instr_cnt  (instr_cnt),
    .halted     (halted)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic        done;
    logic        stall;
    logic        halt;
    logic [29:0] npc;
    logic [31:0] rdata;
    logic        chk;
    logic [29:0] e_pc;
    logic        e_req;
    logic        e_we;
    logic        e_halted;
    logic        e_valid;
    logic [31:0] e_ir;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  localparam logic [31:0] R1 = 32'h1111_1111;
  localparam logic [31:0] R2 = 32'h2222_2222;
  localparam logic [31:0] R3 = 32'h3333_3333;
  localparam logic [31:0] G  = 32'hDEAD_BEEF;
  localparam logic [31:0] I  = 32'h8C01_0004;

  function automatic vec_t v(input logic r, input logic a, input logic d, input logic s,
                             input logic h, input logic [29:0] npc, input logic [31:0] rd,
                             input logic c, input logic [29:0] pc, input logic req,
                             input logic we, input logic hl, input logic vl,
                             input logic [31:0] irv, input logic [31:0] cnt);
    vec_t t;
    t.rst = r; t.ack = a; t.done = d; t.stall = s; t.halt = h;
    t.npc = npc; t.rdata = rd; t.chk = c;
    t.e_pc = pc; t.e_req = req; t.e_we = we; t.e_halted = hl;
    t.e_valid = vl; t.e_ir = irv; t.e_cnt = cnt;
    return t;
  endfunction

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus after the edge, compare at the following negedge.
  task automatic apply(input vec_t t, input int step);
    vec_t e;
    @(posedge clk);
    #1;
    rst        = t.rst;
    imem_ack   = t.ack;
    exec_done  = t.done;
    stall      = t.stall;
    halt_req   = t.halt;
    NPC        = t.npc;
    imem_rdata = t.rdata;
    sb.push_back(t);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk) begin
      check("PC",        step, {2'b00, PC},        {2'b00, e.e_pc});
      check("imem_req",  step, {31'd0, imem_req},  {31'd0, e.e_req});
      check("pc_we",     step, {31'd0, pc_we},     {31'd0, e.e_we});
      check("halted",    step, {31'd0, halted},    {31'd0, e.e_halted});
      check("ir_valid",  step, {31'd0, ir_valid},  {31'd0, e.e_valid});
      check("ir",        step, ir,                 e.e_ir);
      check("instr_cnt", step, instr_cnt,          e.e_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; NPC = '0; imem_rdata = '0; imem_ack = 1'b0;
    exec_done = 1'b0; stall = 1'b0; halt_req = 1'b0;

    // Back-to-back 3-cycle instructions from reset
    tbl.push_back(v(1,0,0,0,0,30'h0,    32'h0, 0,30'h0,   0,0,0,0,32'h0,0));
    tbl.push_back(v(0,1,1,0,0,30'h0C01, R1,    1,30'h0C00,0,0,0,0,32'h0,0));
    tbl.push_back(v(0,1,1,0,0,30'h0C01, R1,    1,30'h0C00,1,0,0,0,32'h0,0));
    tbl.push_back(v(0,1,1,0,0,30'h0C01, R2,    1,30'h0C00,0,0,0,1,R1,0));
    tbl.push_back(v(0,1,1,0,0,30'h0C01, R2,    1,30'h0C00,0,1,0,1,R1,0));
    tbl.push_back(v(0,1,1,0,0,30'h0C02, R2,    1,30'h0C01,1,0,0,0,R1,1));
    tbl.push_back(v(0,1,1,0,0,30'h0C02, R3,    1,30'h0C01,0,0,0,1,R2,1));
    tbl.push_back(v(0,1,1,0,0,30'h0C02, R3,    1,30'h0C01,0,1,0,1,R2,1));
    tbl.push_back(v(0,1,1,0,0,30'h0C03, R3,    1,30'h0C02,1,0,0,0,R2,2));
    tbl.push_back(v(0,1,1,0,0,30'h0C03, G,     1,30'h0C02,0,0,0,1,R3,2));
    tbl.push_back(v(0,0,1,0,0,30'h0C03, G,     1,30'h0C02,0,1,0,1,R3,2));
    // Fetch ack delayed 4 cycles
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0,0,0,0,0,30'h0,  G,     1,30'h0C03,1,0,0,0,R3,3));
    tbl.push_back(v(0,1,0,0,0,30'h0,    I,     1,30'h0C03,1,0,0,0,R3,3));
    // EXEC holds; stray ack and halt_req ignored
    tbl.push_back(v(0,1,0,0,0,30'h0,    G,     1,30'h0C03,0,0,0,1,I,3));
    tbl.push_back(v(0,0,0,0,1,30'h0,    G,     1,30'h0C03,0,0,0,1,I,3));
    tbl.push_back(v(0,0,1,0,0,30'h0,    G,     1,30'h0C03,0,0,0,1,I,3));
    // Two stalled COMMIT cycles then a single pc_we
    tbl.push_back(v(0,0,0,1,0,30'h0D00, G,     1,30'h0C03,0,0,0,1,I,3));
    tbl.push_back(v(0,0,0,1,0,30'h0D00, G,     1,30'h0C03,0,0,0,1,I,3));
    tbl.push_back(v(0,0,0,0,0,30'h0D00, G,     1,30'h0C03,0,1,0,1,I,3));
    tbl.push_back(v(0,1,1,0,0,30'h0D01, R1,    1,30'h0D00,1,0,0,0,I,4));
    tbl.push_back(v(0,1,1,0,0,30'h0D01, R1,    1,30'h0D00,0,0,0,1,R1,4));
    tbl.push_back(v(0,1,1,0,0,30'h0D01, R1,    1,30'h0D00,0,1,0,1,R1,4));
    tbl.push_back(v(0,1,0,0,0,30'h0,    R2,    1,30'h0D01,1,0,0,0,R1,5));
    // Reset mid-EXEC with instr_cnt=5
    tbl.push_back(v(1,0,0,0,0,30'h0,    G,     1,30'h0D01,0,0,0,1,R2,5));
    tbl.push_back(v(0,1,1,0,0,30'h0C10, R3,    1,30'h0C00,0,0,0,0,32'h0,0));
    tbl.push_back(v(0,1,1,0,0,30'h0C10, R3,    1,30'h0C00,1,0,0,0,32'h0,0));
    tbl.push_back(v(0,1,1,0,0,30'h0C10, G,     1,30'h0C00,0,0,0,1,R3,0));
    // Halt on commit; HALT is absorbing
    tbl.push_back(v(0,1,1,0,1,30'h0C10, G,     1,30'h0C00,0,1,0,1,R3,0));
    tbl.push_back(v(0,1,1,0,0,30'h0C20, G,     1,30'h0C10,0,0,1,0,R3,1));
    tbl.push_back(v(0,0,0,0,1,30'h0C20, G,     1,30'h0C10,0,0,1,0,R3,1));
    tbl.push_back(v(0,1,1,0,0,30'h0C20, G,     1,30'h0C10,0,0,1,0,R3,1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset out of HALT, then counter wrap on commit
    apply(v(1,0,0,0,0,30'h0,    32'h0, 1,30'h0C10,0,0,1,0,R3,1),            100);
    apply(v(0,1,1,0,0,30'h0,    R1,    1,30'h0C00,0,0,0,0,32'h0,0),         101);
    apply(v(0,1,0,0,0,30'h0,    R1,    1,30'h0C00,1,0,0,0,32'h0,0),         102);
    apply(v(0,0,0,0,0,30'h0,    G,     1,30'h0C00,0,0,0,1,R1,0),            103);
    force dut.u_ret_counter.count_q = 32'hFFFF_FFFF;
    apply(v(0,0,1,0,0,30'h0,    G,     1,30'h0C00,0,0,0,1,R1,32'hFFFF_FFFF),104);
    release dut.u_ret_counter.count_q;
    apply(v(0,0,0,0,0,30'h0C55, G,     1,30'h0C00,0,1,0,1,R1,32'hFFFF_FFFF),105);
    apply(v(0,0,0,0,0,30'h0,    G,     1,30'h0C55,1,0,0,0,R1,0),            106);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
